// File: rtl/run_seq_pkg.sv
// Shared types and default sizes for the run sequencer.
// Optional feature macro: RUN_SEQ_ABORT_EN (host abort input).
package run_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        RUN    = 2'd2,
        FINISH = 2'd3
    } run_state_t;

    localparam int DEF_AW         = 8;
    localparam int DEF_DW         = 8;
    localparam int DEF_CW         = 16;
    localparam int DEF_RST_CYCLES = 2;
    localparam int DEF_TIMEOUT    = 4096;

endpackage

// File: rtl/run_cycle_counter.sv
// Clearable up-counter with a terminal flag at TERM.
// Used for RUN-length measurement and LAUNCH-length timing.
module run_cycle_counter
    import run_seq_pkg::*;
#(
    parameter int CW   = DEF_CW,
    parameter int TERM = DEF_TIMEOUT - 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          enable,
    output logic [CW-1:0] count,
    output logic          terminal
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: clear wins over enable.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + CW'(1);
        end
    end

    // Count register, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count    = count_q;
    assign terminal = (count_q == CW'(TERM));

endmodule

// File: rtl/run_sequencer.sv
// Run sequencer: core reset/launch/done FSM, timeout, data-memory mux.
// Optional macro RUN_SEQ_ABORT_EN adds a host_abort input.
module run_sequencer
    import run_seq_pkg::*;
#(
    parameter int AW         = DEF_AW,
    parameter int DW         = DEF_DW,
    parameter int CW         = DEF_CW,
    parameter int RST_CYCLES = DEF_RST_CYCLES,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          host_req,
    output logic          host_busy,
    output logic          host_ack,
    output logic          timed_out,
    output logic [CW-1:0] cycle_count,
    output logic          core_reset,
    output logic          core_req,
    input  logic          core_done,
    input  logic          core_mem_we,
    input  logic [AW-1:0] core_mem_addr,
    input  logic [DW-1:0] core_mem_wdata,
    input  logic          hm_req,
    input  logic          hm_we,
    input  logic [AW-1:0] hm_addr,
    input  logic [DW-1:0] hm_wdata,
`ifdef RUN_SEQ_ABORT_EN
    input  logic          host_abort,
`endif
    output logic          hm_gnt,
    output logic          mem_wr_en,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata
);

    run_state_t    state_q, state_d;
    logic          timed_out_q, timed_out_d;
    logic          run_clr, run_en, run_term;
    logic          lch_term;
    logic          abort;
    logic [CW-1:0] lch_count;

`ifdef RUN_SEQ_ABORT_EN
    assign abort = host_abort;
`else
    assign abort = 1'b0;
`endif

    run_cycle_counter #(.CW(CW), .TERM(TIMEOUT - 1)) u_run_cnt (
        .clk      (clk),
        .reset    (reset),
        .clear    (run_clr),
        .enable   (run_en),
        .count    (cycle_count),
        .terminal (run_term)
    );

    // LAUNCH timer: held clear outside LAUNCH so each launch starts at 0.
    run_cycle_counter #(.CW(CW), .TERM(RST_CYCLES - 1)) u_lch_cnt (
        .clk      (clk),
        .reset    (reset),
        .clear    (state_q != LAUNCH),
        .enable   (state_q == LAUNCH),
        .count    (lch_count),
        .terminal (lch_term)
    );

    // Next state, counter control and timeout status.
    always_comb begin
        state_d     = state_q;
        timed_out_d = timed_out_q;
        run_clr     = 1'b0;
        run_en      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (host_req) begin
                    state_d     = LAUNCH;
                    run_clr     = 1'b1;
                    timed_out_d = 1'b0;
                end
            end
            LAUNCH: begin
                if (abort) begin
                    state_d     = FINISH;
                    timed_out_d = 1'b1;
                end else if (lch_term) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d     = FINISH;
                    timed_out_d = 1'b1;
                end else if (core_done) begin
                    state_d = FINISH;
                end else if (run_term) begin
                    state_d     = FINISH;
                    timed_out_d = 1'b1;
                end else begin
                    run_en = 1'b1;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and status registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            timed_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            timed_out_q <= timed_out_d;
        end
    end

    assign host_busy  = (state_q == LAUNCH) || (state_q == RUN);
    assign host_ack   = (state_q == FINISH);
    assign core_req   = (state_q == RUN);
    assign core_reset = (state_q != RUN);
    assign timed_out  = timed_out_q;
    assign hm_gnt     = hm_req && (state_q == IDLE);

    // Memory mux: host when granted, otherwise core stores only in RUN.
    always_comb begin
        mem_wr_en = core_mem_we && (state_q == RUN);
        mem_addr  = core_mem_addr;
        mem_wdata = core_mem_wdata;
        if (hm_gnt) begin
            mem_wr_en = hm_we;
            mem_addr  = hm_addr;
            mem_wdata = hm_wdata;
        end
    end

endmodule
